veripac_mem_master: RTL and testbench

// Bus initiator for the VeriPac 256x8 RAM port (addr/rd/wr/din/dout). Accepts

---
 rtl/veripac_mem_master.sv | 115 +++++++++++
 tb/tb_veripac_mem_master.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/veripac_mem_master.sv
// veripac_mem_master: bus initiator for the VeriPac 256x8 RAM port.
// Takes one host command at a time (WRITE, READ, FILL, SUM) and sequences it
// as one RAM access per clock. The result is held until the host takes it.
module veripac_mem_master #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [ADDR_W-1:0] cmd_len,
    input  logic [DATA_W-1:0] cmd_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              busy,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_RESP   = 2'd2;

    localparam logic [1:0] OP_WRITE = 2'd0;
    localparam logic [1:0] OP_READ  = 2'd1;
    localparam logic [1:0] OP_SUM   = 2'd3;

    logic [1:0]        state;
    logic [1:0]        op;
    logic [ADDR_W-1:0] ptr;
    logic [ADDR_W-1:0] count;
    logic [DATA_W-1:0] sum;
    logic [DATA_W-1:0] sum_next;

    // Running checksum including the byte currently on the read bus.
    always_comb begin
        sum_next = sum + mem_rdata;
    end

    // Command sequencer: accept, one RAM access per cycle, hold response.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            op        <= OP_WRITE;
            ptr       <= '0;
            count     <= '0;
            sum       <= '0;
            cmd_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            busy      <= 1'b0;
            mem_addr  <= '0;
            mem_rd    <= 1'b0;
            mem_wr    <= 1'b0;
            mem_wdata <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        op        <= cmd_op;
                        ptr       <= cmd_addr;
                        count     <= (cmd_op == OP_WRITE || cmd_op == OP_READ) ? '0 : cmd_len;
                        sum       <= '0;
                        cmd_ready <= 1'b0;
                        busy      <= 1'b1;
                        // First access is presented straight from the accept edge.
                        mem_addr  <= cmd_addr;
                        mem_rd    <= cmd_op[0];
                        mem_wr    <= ~cmd_op[0];
                        if (!cmd_op[0]) begin
                            mem_wdata <= cmd_data;
                        end
                        state     <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    if (op == OP_SUM) begin
                        sum <= sum_next;
                    end
                    if (count == '0) begin
                        mem_rd    <= 1'b0;
                        mem_wr    <= 1'b0;
                        rsp_valid <= 1'b1;
                        // sum starts at 0, so for READ sum_next is exactly the byte read.
                        rsp_data  <= op[0] ? sum_next : '0;
                        state     <= S_RESP;
                    end else begin
                        ptr      <= ptr + 1'b1;
                        mem_addr <= ptr + 1'b1;
                        count    <= count - 1'b1;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        busy      <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_veripac_mem_master.sv
// Testbench for veripac_mem_master: RAM model, transaction-level reference
// model checked every cycle, plus directed scenarios with literal expectations.
module tb_veripac_mem_master;

    localparam logic [1:0] OP_WRITE = 2'd0;
    localparam logic [1:0] OP_READ  = 2'd1;
    localparam logic [1:0] OP_FILL  = 2'd2;
    localparam logic [1:0] OP_SUM   = 2'd3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd_op = '0;
    logic [7:0] cmd_addr = '0;
    logic [7:0] cmd_len = '0;
    logic [7:0] cmd_data = '0;
    logic       rsp_valid;
    logic       rsp_ready = 1'b0;
    logic [7:0] rsp_data;
    logic       busy;
    logic [7:0] mem_addr;
    logic       mem_rd;
    logic       mem_wr;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata;

    int n_chk = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    veripac_mem_master #(.ADDR_W(8), .DATA_W(8)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .busy(busy), .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // RAM attached to the DUT.
    logic [7:0] ram [256];
    int wr_count = 0;
    assign mem_rdata = ram[mem_addr];
    always @(posedge clk) begin
        if (mem_wr) begin
            ram[mem_addr] <= mem_wdata;
            wr_count <= wr_count + 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: a command becomes N accesses at start..start+N-1,
    // then a held response; the expected RAM contents are tracked separately.
    logic [7:0] ref_ram [256];
    bit         chk_en = 0;
    bit         m_busy = 0;
    bit         m_rsp = 0;
    bit         m_zero = 0;
    int         m_left = 0;
    int         m_k = 0;
    logic [1:0] m_op = '0;
    logic [7:0] m_start = '0;
    logic [7:0] m_data = '0;
    logic [7:0] m_acc = '0;
    logic [7:0] m_rspdata = '0;
    logic [7:0] m_a;

    always @(posedge clk) begin
        if (m_left > 0) begin
            m_a = m_start + m_k[7:0];
            if (!m_op[0]) ref_ram[m_a] = m_data;
            else          m_acc = m_acc + ref_ram[m_a];
        end
        if (rst) begin
            chk_en = 1; m_busy = 0; m_rsp = 0; m_zero = 1; m_left = 0; m_k = 0;
        end else if (!m_busy) begin
            if (cmd_valid) begin
                m_busy = 1; m_zero = 0; m_op = cmd_op; m_start = cmd_addr;
                m_data = cmd_data; m_acc = '0; m_k = 0;
                m_left = (cmd_op == OP_WRITE || cmd_op == OP_READ) ? 1 : int'(cmd_len) + 1;
            end
        end else if (m_left > 0) begin
            m_k++; m_left--;
            if (m_left == 0) begin
                m_rsp = 1;
                m_rspdata = m_op[0] ? m_acc : 8'h00;
            end
        end else if (m_rsp && rsp_ready) begin
            m_rsp = 0; m_busy = 0;
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("cmd_ready", 32'(cmd_ready), 32'(!m_busy));
            chk("busy", 32'(busy), 32'(m_busy));
            chk("rsp_valid", 32'(rsp_valid), 32'(m_rsp));
            chk("mem_wr", 32'(mem_wr), 32'(m_left > 0 && !m_op[0]));
            chk("mem_rd", 32'(mem_rd), 32'(m_left > 0 && m_op[0]));
            if (m_left > 0) begin
                chk("mem_addr", 32'(mem_addr), 32'(8'(m_start + m_k[7:0])));
                if (!m_op[0]) chk("mem_wdata", 32'(mem_wdata), 32'(m_data));
            end
            if (m_rsp) chk("rsp_data", 32'(rsp_data), 32'(m_rspdata));
            if (m_zero) begin
                chk("rst_mem_addr", 32'(mem_addr), 32'h0);
                chk("rst_mem_wdata", 32'(mem_wdata), 32'h0);
                chk("rst_rsp_data", 32'(rsp_data), 32'h0);
            end
        end
    end

    task automatic run_cmd(input logic [1:0] op, input logic [7:0] addr, input logic [7:0] len,
                           input logic [7:0] data, input int hold, input bit early_ready,
                           output logic [7:0] rd, output int lat);
        int guard;
        rd = '0; lat = -1;
        @(negedge clk);
        cmd_valid = 1; cmd_op = op; cmd_addr = addr; cmd_len = len; cmd_data = data;
        guard = 0;
        while (!cmd_ready && guard < 1000) begin @(negedge clk); guard++; end
        if (!cmd_ready) begin
            chk("accept_timeout", 32'(cmd_ready), 32'h1);
            cmd_valid = 0;
            return;
        end
        @(negedge clk);
        cmd_valid = 0; cmd_op = ~op; cmd_addr = ~addr; cmd_len = ~len; cmd_data = ~data;
        if (early_ready) rsp_ready = 1;
        lat = 0;
        while (!rsp_valid && lat < 1000) begin @(negedge clk); lat++; end
        if (!rsp_valid) begin
            chk("rsp_timeout", 32'(rsp_valid), 32'h1);
            rsp_ready = 0;
            return;
        end
        rd = rsp_data;
        for (int i = 0; i < hold; i++) begin
            cmd_valid = 1; cmd_op = OP_WRITE; cmd_addr = 8'hEE; cmd_data = 8'h99;
            @(negedge clk);
        end
        cmd_valid = 0; rsp_ready = 1;
        @(negedge clk);
        rsp_ready = 0;
    endtask

    logic [7:0] rd;
    int lat;
    int wc0;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) begin ram[i] = 8'h00; ref_ram[i] = 8'h00; end
        repeat (3) @(negedge clk);
        rst = 0;
        chk("reset_cmd_ready", 32'(cmd_ready), 32'h1);
        chk("reset_busy", 32'(busy), 32'h0);
        // rsp_ready while idle must be ignored
        rsp_ready = 1; repeat (2) @(negedge clk); rsp_ready = 0;

        // 1: single write then read-back
        run_cmd(OP_WRITE, 8'h10, 8'h55, 8'hA5, 0, 0, rd, lat);
        chk("t1_write_rsp", 32'(rd), 32'h00);
        chk("t1_write_lat", 32'(lat), 32'd1);
        run_cmd(OP_READ, 8'h10, 8'h00, 8'h00, 0, 0, rd, lat);
        chk("t1_read_rsp", 32'(rd), 32'hA5);
        chk("t1_read_lat", 32'(lat), 32'd1);

        // 2: fill with address wrap; rsp_ready held high during the accesses
        run_cmd(OP_WRITE, 8'h02, 8'h00, 8'h5A, 0, 0, rd, lat);
        run_cmd(OP_FILL, 8'hFE, 8'h03, 8'h3C, 0, 1, rd, lat);
        chk("t2_fill_rsp", 32'(rd), 32'h00);
        chk("t2_fill_lat", 32'(lat), 32'd4);
        run_cmd(OP_READ, 8'h00, 8'h00, 8'h00, 0, 0, rd, lat);
        chk("t2_read00", 32'(rd), 32'h3C);
        run_cmd(OP_READ, 8'hFF, 8'h00, 8'h00, 0, 0, rd, lat);
        chk("t2_readFF", 32'(rd), 32'h3C);
        run_cmd(OP_READ, 8'h02, 8'h00, 8'h00, 0, 0, rd, lat);
        chk("t2_read02", 32'(rd), 32'h5A);

        // 3: checksum over whole RAM and over one byte
        @(negedge clk);
        for (int i = 0; i < 256; i++) begin ram[i] = 8'(i); ref_ram[i] = 8'(i); end
        run_cmd(OP_SUM, 8'h00, 8'hFF, 8'h00, 0, 0, rd, lat);
        chk("t3_sum_all", 32'(rd), 32'h80);
        chk("t3_sum_lat", 32'(lat), 32'd256);
        run_cmd(OP_SUM, 8'h05, 8'h00, 8'h00, 0, 0, rd, lat);
        chk("t3_sum_one", 32'(rd), 32'h05);

        // 4: response held 10 cycles while a new command is offered
        run_cmd(OP_READ, 8'h10, 8'h00, 8'h00, 10, 0, rd, lat);
        chk("t4_read_rsp", 32'(rd), 32'h10);
        chk("t4_ram_EE", 32'(ram[8'hEE]), 32'hEE);

        // 5: reset during the third access cycle of an 8-byte fill
        @(negedge clk);
        wc0 = wr_count;
        cmd_valid = 1; cmd_op = OP_FILL; cmd_addr = 8'h40; cmd_len = 8'h07; cmd_data = 8'hC3;
        @(negedge clk);
        cmd_valid = 0;
        @(negedge clk);
        @(negedge clk);
        rst = 1;
        @(negedge clk);
        rst = 0;
        chk("t5_writes", 32'(wr_count - wc0), 32'd3);
        chk("t5_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("t5_cmd_ready", 32'(cmd_ready), 32'h1);
        chk("t5_mem_wr", 32'(mem_wr), 32'h0);
        chk("t5_ram42", 32'(ram[8'h42]), 32'hC3);
        chk("t5_ram43", 32'(ram[8'h43]), 32'h43);
        run_cmd(OP_READ, 8'h42, 8'h00, 8'h00, 0, 0, rd, lat);
        chk("t5_read42", 32'(rd), 32'hC3);
        chk("t5_read_lat", 32'(lat), 32'd1);

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
